// File: rtl/cache_pkg.sv
// Shared cache geometry, field types and refill FSM encoding.
// Imported by the lookup stage and by the line refill block.
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int INDEX_W        = 8;
    localparam int OFFSET_W       = 4;
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORDS_PER_LINE = 1 << OFFSET_W;

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;
    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [ADDR_W-1:0]   addr_t;

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_INVAL  = 2'd1,
        RS_FETCH  = 2'd2,
        RS_COMMIT = 2'd3
    } refill_state_t;

    function automatic tag_t addr_tag(input addr_t a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/cache_line_refill.sv
// Line refill for the direct-mapped cache: invalidate tag, fetch 16 words
// critical-word-first with wrap, write them, then commit the valid tag.
module cache_line_refill
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                miss_valid,
    input  logic [ADDR_W-1:0]   miss_addr,
    output logic                miss_ready,
    output logic                mem_rd_req,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic                mem_rd_ack,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                fill_we,
    output logic [INDEX_W-1:0]  fill_index,
    output logic [OFFSET_W-1:0] fill_offset,
    output logic [DATA_W-1:0]   fill_data,
    output logic                tag_we,
    output logic                tag_valid,
    output logic [TAG_W-1:0]    tag_data,
    output logic                crit_valid,
    output logic [DATA_W-1:0]   crit_data,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] S_IDLE   = RS_IDLE;
    localparam logic [1:0] S_INVAL  = RS_INVAL;
    localparam logic [1:0] S_FETCH  = RS_FETCH;
    localparam logic [1:0] S_COMMIT = RS_COMMIT;

    localparam offset_t LAST_WORD = offset_t'(WORDS_PER_LINE - 1);

    logic [1:0] state_reg, state_next;
    addr_t      addr_reg, addr_next;
    offset_t    ptr_reg, ptr_next;
    offset_t    cnt_reg, cnt_next;
    logic       fill_we_reg, fill_we_next;
    offset_t    fill_offset_reg, fill_offset_next;
    word_t      fill_data_reg, fill_data_next;
    logic       crit_valid_reg, crit_valid_next;
    word_t      crit_data_reg, crit_data_next;

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        ptr_next         = ptr_reg;
        cnt_next         = cnt_reg;
        fill_we_next     = 1'b0;
        fill_offset_next = fill_offset_reg;
        fill_data_next   = fill_data_reg;
        crit_valid_next  = 1'b0;
        crit_data_next   = crit_data_reg;

        case (state_reg)
            S_IDLE: begin
                if (miss_valid) begin
                    addr_next  = miss_addr;
                    ptr_next   = addr_offset(miss_addr);
                    cnt_next   = '0;
                    state_next = S_INVAL;
                end
            end
            S_INVAL: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_rd_ack) begin
                    fill_we_next     = 1'b1;
                    fill_offset_next = ptr_reg;
                    fill_data_next   = mem_rd_data;
                    // Offset arithmetic wraps naturally at the line boundary.
                    ptr_next         = ptr_reg + offset_t'(1);
                    cnt_next         = cnt_reg + offset_t'(1);
                    if (cnt_reg == '0) begin
                        crit_valid_next = 1'b1;
                        crit_data_next  = mem_rd_data;
                    end
                    if (cnt_reg == LAST_WORD) begin
                        state_next = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            addr_reg        <= '0;
            ptr_reg         <= '0;
            cnt_reg         <= '0;
            fill_we_reg     <= 1'b0;
            fill_offset_reg <= '0;
            fill_data_reg   <= '0;
            crit_valid_reg  <= 1'b0;
            crit_data_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            ptr_reg         <= ptr_next;
            cnt_reg         <= cnt_next;
            fill_we_reg     <= fill_we_next;
            fill_offset_reg <= fill_offset_next;
            fill_data_reg   <= fill_data_next;
            crit_valid_reg  <= crit_valid_next;
            crit_data_reg   <= crit_data_next;
        end
    end

    // Strobes decode from state only, so an asynchronous reset removes them
    // before the next edge and no array write can follow it.
    assign miss_ready  = (state_reg == S_IDLE);
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_COMMIT);
    assign mem_rd_req  = (state_reg == S_FETCH);
    assign mem_rd_addr = (state_reg == S_FETCH) ? {addr_reg[ADDR_W-1:OFFSET_W], ptr_reg} : '0;
    assign tag_we      = (state_reg == S_INVAL) || (state_reg == S_COMMIT);
    assign tag_valid   = (state_reg == S_COMMIT);
    assign tag_data    = addr_tag(addr_reg);
    assign fill_index  = addr_index(addr_reg);
    assign fill_we     = fill_we_reg;
    assign fill_offset = fill_offset_reg;
    assign fill_data   = fill_data_reg;
    assign crit_valid  = crit_valid_reg;
    assign crit_data   = crit_data_reg;

endmodule

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Miss-handling stage directly downstream of the direct-mapped cache lookup.
- On a reported miss it fetches the whole 16-word line from backing memory over a per-word req/ack handshake, critical word first with wrap-around.
- Writes each word into the cache data array and forwards the critical word to the requester.
- Invalidates the line's tag at fill start and writes the new valid tag only after the final word, so a partially filled line can never hit.

Parameters:
- ADDR_W, 32, word address width.
- DATA_W, 32, data word width.
- INDEX_W, 8, cache set index width (256 lines).
- OFFSET_W, 4, word-in-line offset width (16 words per line).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W (20), tag width; derived, not overridable.

Ports:
- clk  in  1  — single clock, rising edge.
- rst_n  in  1  — asynchronous active-low reset.
- miss_valid  in  1  — miss request from the lookup stage.
- miss_addr  in  ADDR_W  — word address that missed; decoded as tag[31:12], index[11:4], offset[3:0].
- miss_ready  out  1  — block is idle and accepts a miss.
- mem_rd_req  out  1  — memory read request.
- mem_rd_addr  out  ADDR_W  — word address being read.
- mem_rd_ack  in  1  — memory returns data this cycle.
- mem_rd_data  in  DATA_W  — read data, valid when mem_rd_ack=1.
- fill_we  out  1  — data array write strobe.
- fill_index  out  INDEX_W  — line index, for both data and tag writes.
- fill_offset  out  OFFSET_W  — word offset for the data write.
- fill_data  out  DATA_W  — word to write.
- tag_we  out  1  — tag array write strobe.
- tag_valid  out  1  — valid bit written with the tag.
- tag_data  out  TAG_W  — tag value written.
- crit_valid  out  1  — one-cycle pulse: critical word available.
- crit_data  out  DATA_W  — critical word.
- busy  out  1  — a fill is in progress.
- done  out  1  — one-cycle pulse: fill complete.

Behaviour:
- Reset: every output is 0 except miss_ready=1. State=IDLE; word counter, pointer and captured address are cleared. Reset is asynchronous assert, synchronous deassert by clk.
- FSM states: IDLE, INVAL, FETCH, COMMIT.
- IDLE:
  - miss_ready=1.
  - On miss_valid&miss_ready: capture miss_addr; ptr=miss_addr[3:0]; cnt=0; go to INVAL.
- INVAL (1 cycle):
  - tag_we=1, tag_valid=0, fill_index=captured index, tag_data=captured tag.
  - busy=1; go to FETCH.
- FETCH:
  - mem_rd_req=1; mem_rd_addr={captured addr[31:4], ptr}.
  - mem_rd_req and mem_rd_addr stay stable until mem_rd_ack.
  - On ack: register fill_we=1, fill_offset=ptr, fill_data=mem_rd_data. These are visible the next cycle as a one-cycle strobe.
  - On ack: ptr=ptr+1 mod 16 (wrap 15->0); cnt=cnt+1.
  - On the ack with cnt=0: crit_valid=1 and crit_data=mem_rd_data, also registered (same cycle as the first fill_we).
  - Back-to-back acks are legal; mem_rd_req stays high in the cycle after an ack when more words remain.
  - On the ack with cnt=15: go to COMMIT, and mem_rd_req drops the next cycle.
- COMMIT (1 cycle):
  - Last fill_we is visible.
  - tag_we=1, tag_valid=1, tag_data=captured tag; done=1.
  - Go to IDLE.
- miss_ready=0 in every non-IDLE state. A requester holds miss_valid/miss_addr until accepted.
- busy=1 in INVAL, FETCH and COMMIT.
- mem_rd_ack outside FETCH is ignored; no writes occur.
- Latency:
  - Acceptance to first mem_rd_req is 2 cycles.
  - With zero-wait memory (ack every cycle), acceptance to done is 18 cycles.
  - Minimum throughput is one fill per 19 cycles.
- Offset 0 miss: fill order is 0..15, with no wrap.
- Reset mid-FETCH:
  - Fill is abandoned; the tag for that index stays invalid (written in INVAL).
  - No further writes occur; mem_rd_req drops immediately.
- Reset during INVAL before the edge: no tag write; the old line remains intact.
- miss_valid asserted in the same cycle as done: not accepted; accepted the following cycle in IDLE.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W, DATA_W, INDEX_W, OFFSET_W, TAG_W and WORDS_PER_LINE=1<<OFFSET_W;
  - typedefs tag_t, index_t, offset_t, word_t;
  - refill_state_t enum (IDLE, INVAL, FETCH, COMMIT).
- The lookup stage and this block both import cache_pkg.
- No sub-module; the pointer/counter and FSM are small enough to live inline.

Test Plan:
1. Reset hold then release, no stimulus -> miss_ready=1, all other outputs 0, mem_rd_req never asserts.
2. Miss at 0x0000_1230, zero-wait memory returning data=addr -> tag invalidate at index 0x23 with tag 0x00001; reads 0x1230..0x123F in order; 16 fill_we with fill_data==address; tag_we valid=1 tag 0x00001; done 18 cycles after acceptance.
3. Miss at 0x0000_123D -> read order offsets D,E,F,0..C; crit_valid once with data 0x123D; fill_offset wraps 15->0; done once.
4. Memory with 3-cycle ack delay per word -> mem_rd_addr stable while waiting; exactly 16 fill_we; second miss_valid held during fill is not accepted until the cycle after done.
5. rst_n pulled low after 5 acks of a fill at 0x0000_1230 -> outputs return to reset values asynchronously; last tag write was valid=0 for index 0x23; no COMMIT tag write occurs.
6. Spurious mem_rd_ack in IDLE and COMMIT -> no fill_we, no state change.
